uart_tx_arbiter: RTL

- Shares the single UART transmitter between two requesters:
  - the echo path, which returns received characters to the terminal;
  - the result path, which is the TX FIFO draining calculator output characters.
- Keeps result lines atomic: once a result line starts, echo characters wait until the line terminator is sent or the line stalls past a timeout.
- Sits between the ASCII converters / TX FIFO and the uart block at top level.

---
 rtl/uart_tx_arbiter_if.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the echo/result requesters, the UART transmitter and the TX arbiter.
// The arbiter takes the slave side; whatever drives the requesters and UART takes the master side.
interface uart_tx_arbiter_if;
    logic       i_echo_wr;
    logic [7:0] i_echo_data;
    logic       i_res_empty;
    logic [7:0] i_res_data;
    logic       o_res_rd;
    logic       o_tx_start;
    logic [7:0] o_tx_data;
    logic       i_tx_done;
    logic       o_locked;
    logic       o_echo_ovf;

    modport slave (
        input  i_echo_wr, i_echo_data, i_res_empty, i_res_data, i_tx_done,
        output o_res_rd, o_tx_start, o_tx_data, o_locked, o_echo_ovf
    );

    modport master (
        output i_echo_wr, i_echo_data, i_res_empty, i_res_data, i_tx_done,
        input  o_res_rd, o_tx_start, o_tx_data, o_locked, o_echo_ovf
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between echoed input and calculator result lines,
// keeping a result line atomic until its terminator is sent or the line stalls.
//
// state | meaning
// IDLE  | evaluate echo/result requests, grant one per cycle
// BUSY  | character held on o_tx_start/o_tx_data until i_tx_done
module uart_tx_arbiter #(
    parameter int         ECHO_DEPTH   = 4,
    parameter logic [7:0] TERM_CHAR    = 8'h0A,
    parameter int         LOCK_TIMEOUT = 65535
) (
    input logic              i_clk,
    input logic              i_rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int AW = $clog2(ECHO_DEPTH);
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(ECHO_DEPTH);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [7:0]    echo_mem [ECHO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   echo_cnt;
    logic          last_res;
    logic [CW-1:0] lock_cnt;
    logic          echo_req;
    logic          res_req;
    logic          grant_echo;
    logic          grant_res;
    logic          push_ok;

    always_comb begin
        echo_req   = (echo_cnt != '0);
        res_req    = ~bus.i_res_empty;
        grant_echo = 1'b0;
        grant_res  = 1'b0;
        if (state == IDLE && !i_rst) begin
            if (bus.o_locked) begin
                grant_res = res_req;
            end else if (echo_req && res_req) begin
                // round-robin: the side that did not win last time goes first
                grant_res  = ~last_res;
                grant_echo = last_res;
            end else begin
                grant_res  = res_req;
                grant_echo = echo_req;
            end
        end
    end

    // popping the result head in the grant cycle keeps capture and pop in one edge
    assign bus.o_res_rd = grant_res;
    assign push_ok      = bus.i_echo_wr && ((echo_cnt != DEPTH_C) || grant_echo);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            echo_cnt       <= '0;
            bus.o_echo_ovf <= 1'b0;
        end else begin
            if (push_ok) begin
                echo_mem[wr_ptr] <= bus.i_echo_data;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (grant_echo) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !grant_echo) begin
                echo_cnt <= echo_cnt + 1'b1;
            end else if (!push_ok && grant_echo) begin
                echo_cnt <= echo_cnt - 1'b1;
            end
            if (bus.i_echo_wr && !push_ok) begin
                bus.o_echo_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            bus.o_tx_start <= 1'b0;
            bus.o_tx_data  <= 8'h00;
            bus.o_locked   <= 1'b0;
            lock_cnt       <= '0;
            last_res       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_res) begin
                        bus.o_tx_data  <= bus.i_res_data;
                        bus.o_tx_start <= 1'b1;
                        bus.o_locked   <= (bus.i_res_data != TERM_CHAR);
                        lock_cnt       <= '0;
                        last_res       <= 1'b1;
                        state          <= BUSY;
                    end else if (grant_echo) begin
                        bus.o_tx_data  <= echo_mem[rd_ptr];
                        bus.o_tx_start <= 1'b1;
                        last_res       <= 1'b0;
                        state          <= BUSY;
                    end else if (bus.o_locked && bus.i_res_empty) begin
                        // a stalled line must not starve the echo path forever
                        if (lock_cnt == LOCK_LAST) begin
                            bus.o_locked <= 1'b0;
                            lock_cnt     <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (bus.i_tx_done) begin
                        bus.o_tx_start <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
